frame_move_sequencer: RTL

- Per-frame controller that owns and updates the player box X position.
- Detects the start of vertical blanking from the VGA timing coordinates, then runs a short FSM: sample keys, compute step, clamp, commit.
- Updates only during blanking, so the renderer never sees a mid-frame position change.
- Sits between the vga_driver coordinate outputs and the renderer's player_x input, replacing free-running movement logic.

---
 rtl/frame_move_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/frame_move_sequencer.sv
// Per-frame player X controller: samples keys at blanking entry and
// commits one clamped position update per frame.
module frame_move_sequencer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BOX_WIDTH   = 30,
    parameter int MOVE_STEP   = 4,
    parameter int HOLD_FRAMES = 8,
    parameter int X_START     = 305
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  y,
    input  logic        key_left_n,
    input  logic        key_right_n,
    input  logic        pause,
    output logic [9:0]  player_x_pos,
    output logic        frame_tick,
    output logic        update_busy,
    output logic [15:0] frame_count
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [10:0] MAX_X = 11'(H_ACTIVE - BOX_WIDTH);
    localparam logic [10:0] STEP1 = 11'(MOVE_STEP);
    localparam logic [10:0] STEP2 = 11'(2 * MOVE_STEP);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_COMPUTE, S_CLAMP, S_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE, DIR_LEFT, DIR_RIGHT
    } dir_t;

    logic [1:0]    left_sync;
    logic [1:0]    right_sync;
    logic          left_s;
    logic          right_s;
    logic          vblank;
    logic          vblank_d;
    state_t        state;
    dir_t          dir;
    dir_t          dir_now;
    logic [HW-1:0] hold_cnt;
    logic [10:0]   step;
    logic [10:0]   cand;
    logic          underflow;
    logic [9:0]    clamped;

    always_ff @(posedge clk) begin
        if (rst) begin
            left_sync  <= 2'b11;
            right_sync <= 2'b11;
        end else begin
            left_sync  <= {left_sync[0], key_left_n};
            right_sync <= {right_sync[0], key_right_n};
        end
    end

    assign left_s  = ~left_sync[1];
    assign right_s = ~right_sync[1];

    assign vblank     = (y >= 10'(V_ACTIVE));
    assign frame_tick = vblank & ~vblank_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblank_d    <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            vblank_d <= vblank;
            if (frame_tick)
                frame_count <= frame_count + 16'd1;
        end
    end

    always_comb begin
        dir_now = DIR_NONE;
        if (!pause && left_s && !right_s)
            dir_now = DIR_LEFT;
        else if (!pause && right_s && !left_s)
            dir_now = DIR_RIGHT;
    end

    assign step = (hold_cnt >= HOLD_MAX) ? STEP2 : STEP1;

    always_comb begin
        clamped = cand[9:0];
        if (underflow)
            clamped = 10'd0;
        else if (cand > MAX_X)
            clamped = MAX_X[9:0];
    end

    // dir doubles as the previous frame's direction for the hold test.
    // The position register loads as COMMIT is entered, so the new value
    // is visible for the whole COMMIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            update_busy  <= 1'b0;
            player_x_pos <= 10'(X_START);
            hold_cnt     <= '0;
            dir          <= DIR_NONE;
            cand         <= 11'd0;
            underflow    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (frame_tick) begin
                        state       <= S_LATCH;
                        update_busy <= 1'b1;
                    end
                end
                S_LATCH: begin
                    dir <= dir_now;
                    if (dir_now == DIR_NONE)
                        hold_cnt <= '0;
                    else if (dir_now == dir)
                        hold_cnt <= (hold_cnt >= HOLD_MAX) ?
                                    HOLD_MAX : hold_cnt + HW'(1);
                    else
                        hold_cnt <= HW'(1);
                    state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    unique case (dir)
                        DIR_RIGHT: begin
                            cand      <= {1'b0, player_x_pos} + step;
                            underflow <= 1'b0;
                        end
                        DIR_LEFT: begin
                            cand      <= {1'b0, player_x_pos} - step;
                            underflow <= ({1'b0, player_x_pos} < step);
                        end
                        default: begin
                            cand      <= {1'b0, player_x_pos};
                            underflow <= 1'b0;
                        end
                    endcase
                    state <= S_CLAMP;
                end
                S_CLAMP: begin
                    player_x_pos <= clamped;
                    state        <= S_COMMIT;
                end
                S_COMMIT: begin
                    state       <= S_IDLE;
                    update_busy <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    update_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
